// File: rtl/capture_streamer.sv
// capture_streamer
//   Drain stage for the USB sniffer sample RAM. Reads captured 32-bit words
//   as a read-only Wishbone master between its own read pointer and the
//   sniffer's write pointer. It sends each word LSB-first as an 8-bit
//   valid/ready byte stream.
//
//   Optional build macro: CAPTURE_STREAMER_PREFETCH_EN
//     When defined, a second word buffer is added. The next word is read
//     while the current one is being sent. With tx_ready_i held high this
//     gives a sustained 1 byte/cycle.
//
//   Ports
//     clk_i, rst_i       clock, asynchronous active-high reset
//     enable_i           streaming enable (a word in progress always completes)
//     flush_i            pulse: discard unread data (rd_ptr := wr_ptr_i)
//     wr_ptr_i           sniffer next-write word index
//     rd_ptr_o           next word index to read
//     level_o            unread words, wr_ptr_i - rd_ptr_o mod 2^PTR_W
//     busy_o             FSM not idle
//     mem_*              Wishbone read master (sel=F, we=0, pipelined stall)
//     tx_data_o/valid_o  byte stream out, tx_ready_i sink ready
module capture_streamer #(
   parameter int unsigned PTR_W     = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             flush_i,
   input  logic [PTR_W-1:0] wr_ptr_i,
   output logic [PTR_W-1:0] rd_ptr_o,
   output logic [PTR_W-1:0] level_o,
   output logic             busy_o,
   output logic [31:0]      mem_addr_o,
   output logic [3:0]       mem_sel_o,
   output logic             mem_we_o,
   output logic             mem_stb_o,
   input  logic             mem_stall_i,
   input  logic             mem_ack_i,
   input  logic [31:0]      mem_data_i,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i
);

   typedef enum logic [1:0] {IDLE, REQ, ACK, SEND} state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
   logic [31:0]      word_q, word_d;
   logic [31:0]      addr_q, addr_d;
   logic [1:0]       idx_q, idx_d;
   logic             flush_pend_q, flush_pend_d;
   logic             flush_now, xfer, last_xfer, rd_done, drop;

   function automatic logic [31:0] word_addr(input logic [PTR_W-1:0] p);
      return BASE_ADDR + (32'(p) << 2);
   endfunction

   assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
   assign flush_now  = flush_i | flush_pend_q;
   assign xfer       = (state_q == SEND) & tx_ready_i;
   assign last_xfer  = xfer & (idx_q == 2'd3);
   assign rd_done    = mem_ack_i & (((state_q == REQ) & ~mem_stall_i) | (state_q == ACK));

`ifdef CAPTURE_STREAMER_PREFETCH_EN
   typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_WAIT} pf_state_t;

   pf_state_t   pf_state_q, pf_state_d;
   logic [31:0] pf_word_q, pf_word_d;
   logic        pf_valid_q, pf_valid_d;
   logic        discard_q, discard_d;
   logic        pf_ack_now, keep;

   assign pf_ack_now = mem_ack_i & ((pf_state_q == PF_WAIT) |
                                    ((pf_state_q == PF_REQ) & ~mem_stall_i));
   assign keep       = enable_i & ~flush_now;
   assign drop       = discard_q;
   assign mem_stb_o  = (state_q == REQ) | (pf_state_q == PF_REQ);
`else
   assign drop       = 1'b0;
   assign mem_stb_o  = (state_q == REQ);
`endif

   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      word_d       = word_q;
      addr_d       = addr_q;
      idx_d        = idx_q;
      flush_pend_d = flush_pend_q | flush_i;
`ifdef CAPTURE_STREAMER_PREFETCH_EN
      pf_state_d   = pf_state_q;
      pf_word_d    = pf_word_q;
      pf_valid_d   = pf_valid_q;
      discard_d    = discard_q;
      if ((pf_state_q == PF_REQ) && !mem_stall_i) pf_state_d = PF_WAIT;
      if (pf_ack_now) begin
         pf_word_d  = mem_data_i;
         pf_valid_d = 1'b1;
         pf_state_d = PF_IDLE;
      end
`endif

      case (state_q)
         IDLE: begin
            // flush beats a pending request in the same cycle
            if (flush_i) begin
               rd_ptr_d = wr_ptr_i;
            end else if (enable_i && (rd_ptr_q != wr_ptr_i)) begin
               state_d = REQ;
               addr_d  = word_addr(rd_ptr_q);
            end
         end
         REQ, ACK: begin
            if ((state_q == REQ) && !mem_stall_i) state_d = ACK;
            if (rd_done) begin
               if (drop) begin
                  state_d = IDLE;
               end else begin
                  word_d  = mem_data_i;
                  idx_d   = '0;
                  state_d = SEND;
               end
            end
         end
         SEND: begin
            if (xfer) idx_d = idx_q + 2'd1;
            if (last_xfer) begin
               rd_ptr_d = rd_ptr_nxt;
`ifdef CAPTURE_STREAMER_PREFETCH_EN
               pf_valid_d = 1'b0;
               pf_state_d = PF_IDLE;
               if (pf_valid_q || pf_ack_now) begin
                  if (keep) word_d = pf_valid_q ? pf_word_q : mem_data_i;
                  else      state_d = IDLE;
               end else if (pf_state_q == PF_REQ) begin
                  // Hand the in-flight prefetch to the main FSM; addr_q already
                  // holds its address. When not kept, its ack is only absorbed.
                  state_d   = mem_stall_i ? REQ : ACK;
                  discard_d = ~keep;
               end else if (pf_state_q == PF_WAIT) begin
                  state_d   = ACK;
                  discard_d = ~keep;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
`ifdef CAPTURE_STREAMER_PREFETCH_EN
            if (!last_xfer && !pf_valid_q && (pf_state_q == PF_IDLE) &&
                enable_i && !flush_now && (rd_ptr_nxt != wr_ptr_i)) begin
               pf_state_d = PF_REQ;
               addr_d     = word_addr(rd_ptr_nxt);
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      // A flush pending from a busy state lands on IDLE entry and overrides
      // the pointer increment made on the last byte.
      if ((state_d == IDLE) && (state_q != IDLE)) begin
         if (flush_now) rd_ptr_d = wr_ptr_i;
         flush_pend_d = 1'b0;
`ifdef CAPTURE_STREAMER_PREFETCH_EN
         discard_d  = 1'b0;
         pf_valid_d = 1'b0;
         pf_state_d = PF_IDLE;
`endif
      end
      if (state_q == IDLE) flush_pend_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         rd_ptr_q     <= '0;
         word_q       <= '0;
         addr_q       <= BASE_ADDR;
         idx_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         word_q       <= word_d;
         addr_q       <= addr_d;
         idx_q        <= idx_d;
         flush_pend_q <= flush_pend_d;
      end
   end

`ifdef CAPTURE_STREAMER_PREFETCH_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pf_state_q <= PF_IDLE;
         pf_word_q  <= '0;
         pf_valid_q <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         pf_state_q <= pf_state_d;
         pf_word_q  <= pf_word_d;
         pf_valid_q <= pf_valid_d;
         discard_q  <= discard_d;
      end
   end
`endif

   assign rd_ptr_o   = rd_ptr_q;
   assign level_o    = wr_ptr_i - rd_ptr_q;
   assign busy_o     = (state_q != IDLE);
   assign mem_addr_o = mem_stb_o ? addr_q : word_addr(rd_ptr_q);
   assign mem_sel_o  = 4'hF;
   assign mem_we_o   = 1'b0;
   assign tx_valid_o = (state_q == SEND);
   assign tx_data_o  = word_q[{idx_q, 3'b000} +: 8];

endmodule

// File: tb/tb_capture_streamer.sv
// tb_capture_streamer
//   Directed bench for capture_streamer. Stimulus pushes expected reads and
//   bytes into queues; a monitor pops and compares them as the DUT presents
//   them. The bench also models a 1-cycle-ack Wishbone RAM with optional stall.
module tb_capture_streamer;
   localparam int unsigned PTR_W = 12;
   localparam logic [31:0] BASE  = 32'h0004_0000;
`ifdef CAPTURE_STREAMER_PREFETCH_EN
   localparam int unsigned WORD_GAP = 1;
   localparam int unsigned SPAN8    = 31;
`else
   localparam int unsigned WORD_GAP = 4;
   localparam int unsigned SPAN8    = 52;
`endif

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             enable_i = 1'b0;
   logic             flush_i = 1'b0;
   logic [PTR_W-1:0] wr_ptr_i = '0;
   logic [PTR_W-1:0] rd_ptr_o, level_o;
   logic             busy_o;
   logic [31:0]      mem_addr_o;
   logic [3:0]       mem_sel_o;
   logic             mem_we_o, mem_stb_o;
   logic             mem_stall_i = 1'b0;
   logic             mem_ack_i = 1'b0;
   logic [31:0]      mem_data_i = '0;
   logic [7:0]       tx_data_o;
   logic             tx_valid_o;
   logic             tx_ready_i = 1'b1;

   capture_streamer #(.PTR_W(PTR_W), .BASE_ADDR(BASE)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
      .wr_ptr_i(wr_ptr_i), .rd_ptr_o(rd_ptr_o), .level_o(level_o), .busy_o(busy_o),
      .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_we_o(mem_we_o),
      .mem_stb_o(mem_stb_o), .mem_stall_i(mem_stall_i), .mem_ack_i(mem_ack_i),
      .mem_data_i(mem_data_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
      .tx_ready_i(tx_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [31:0] addr; int unsigned hold; } rd_exp_t;

   rd_exp_t     exp_rd_q[$];
   logic [7:0]  exp_byte_q[$];
   int unsigned xfer_log[$];
   rd_exp_t     mon_e;
   logic [31:0] ram [0:4095];
   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc = 0;
   int unsigned n_xfer = 0;
   int unsigned stall_req = 0;
   int unsigned stall_used = 0;
   logic        ready_mode = 1'b0;
   logic        acc_q = 1'b0;
   logic [31:0] acc_addr_q = '0;
   logic [31:0] off;
   logic        hold_pend = 1'b0;
   logic [7:0]  hold_byte = '0;
   int unsigned stb_cnt = 0;
   logic [31:0] stb_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk_i) begin
      cyc        <= cyc + 1;
      acc_q      <= mem_stb_o & ~mem_stall_i;
      acc_addr_q <= mem_addr_o;
   end

   // RAM slave and sink driver: ack one cycle after accept, stall on request
   always @(negedge clk_i) begin
      off        = acc_addr_q - BASE;
      mem_ack_i  = acc_q;
      mem_data_i = acc_q ? ram[off[13:2]] : 32'hDEAD_BEEF;
      if (mem_stb_o && (stall_used < stall_req)) begin
         mem_stall_i = 1'b1;
         stall_used++;
      end else begin
         mem_stall_i = 1'b0;
      end
      tx_ready_i = ready_mode ? ~tx_ready_i : 1'b1;
   end

   // Monitor
   always @(negedge clk_i) begin
      #2;
      if (!rst_i) begin
         if (hold_pend) begin
            check("tx_hold_valid", 32'(tx_valid_o), 32'd1);
            check("tx_hold_data", 32'(tx_data_o), 32'(hold_byte));
         end
         hold_pend = tx_valid_o && !tx_ready_i;
         hold_byte = tx_data_o;
         if (tx_valid_o && tx_ready_i) begin
            n_xfer++;
            xfer_log.push_back(cyc);
            if (exp_byte_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL tx_byte: got unexpected byte %0h, expected none", tx_data_o);
            end else begin
               check("tx_byte", 32'(tx_data_o), 32'(exp_byte_q.pop_front()));
            end
         end
         if (mem_stb_o) begin
            if (stb_cnt > 0) check("stb_addr_stable", mem_addr_o, stb_addr);
            stb_addr = mem_addr_o;
            stb_cnt++;
            if (!mem_stall_i) begin
               check("mem_sel", 32'(mem_sel_o), 32'hF);
               check("mem_we", 32'(mem_we_o), 32'd0);
               if (exp_rd_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL rd_addr: got unexpected read at %0h, expected none", mem_addr_o);
               end else begin
                  mon_e = exp_rd_q.pop_front();
                  check("rd_addr", mem_addr_o, mon_e.addr);
                  check("rd_hold", stb_cnt, mon_e.hold);
               end
               stb_cnt = 0;
            end
         end
      end
   end

   task automatic push_read(input int unsigned idx, input int unsigned hold);
      rd_exp_t e;
      e.addr = BASE + (idx << 2);
      e.hold = hold;
      exp_rd_q.push_back(e);
   endtask

   task automatic push_word(input int unsigned idx, input logic [31:0] w, input int unsigned hold);
      ram[idx] = w;
      push_read(idx, hold);
      for (int unsigned b = 0; b < 4; b++) exp_byte_q.push_back(w[8*b +: 8]);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (!busy_o && exp_byte_q.size() == 0 && exp_rd_q.size() == 0) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got busy=%0d bytes_left=%0d reads_left=%0d, expected idle and drained",
               name, busy_o, exp_byte_q.size(), exp_rd_q.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned start;
      logic [31:0] w;

      // reset state
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_rd_ptr", 32'(rd_ptr_o), 32'd0);
      check("rst_stb", 32'(mem_stb_o), 32'd0);
      check("rst_valid", 32'(tx_valid_o), 32'd0);
      check("rst_data", 32'(tx_data_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_addr", mem_addr_o, BASE);
      rst_i = 1'b0;
      @(negedge clk_i);

      // single word
      push_word(0, 32'h4433_2211, 1);
      wr_ptr_i = 12'd1;
      enable_i = 1'b1;
      wait_idle("t1");
      #1;
      check("t1_rd_ptr", 32'(rd_ptr_o), 32'd1);
      check("t1_level", 32'(level_o), 32'd0);
      check("t1_busy", 32'(busy_o), 32'd0);

      // stalled request and toggling ready
      stall_req  = stall_req + 3;
      ready_mode = 1'b1;
      push_word(1, 32'hDDCC_BBAA, 4);
      wr_ptr_i = 12'd2;
      wait_idle("t2");
      ready_mode = 1'b0;
      #1;
      check("t2_rd_ptr", 32'(rd_ptr_o), 32'd2);
      check("t2_level", 32'(level_o), 32'd0);

      // flush in IDLE wins over a request
      wr_ptr_i = 12'd4095;
      flush_i  = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      check("t3_flush_rd_ptr", 32'(rd_ptr_o), 32'd4095);
      check("t3_flush_busy", 32'(busy_o), 32'd0);
      enable_i = 1'b0;
      wr_ptr_i = 12'd1;
      @(negedge clk_i);
      #1;
      check("t3_level_wrap", 32'(level_o), 32'd2);
      check("t3_idle_disabled", 32'(busy_o), 32'd0);

      // pointer wrap 4095 -> 0
      push_word(4095, 32'h8765_4321, 1);
      push_word(0, 32'h4433_2211, 1);
      xfer_log.delete();
      enable_i = 1'b1;
      wait_idle("t3");
      #1;
      check("t3_rd_ptr", 32'(rd_ptr_o), 32'd1);
      check("t3_level", 32'(level_o), 32'd0);
      check("t3_nbytes", xfer_log.size(), 32'd8);
      if (xfer_log.size() == 8) check("t3_word_gap", xfer_log[4] - xfer_log[3], WORD_GAP);

      // enable dropped after the second byte
      enable_i = 1'b0;
      ram[2] = 32'hB4B3_B2B1;
      ram[3] = 32'hC4C3_C2C1;
      push_word(1, 32'hA4A3_A2A1, 1);
`ifdef CAPTURE_STREAMER_PREFETCH_EN
      push_read(2, 1);
`endif
      start    = n_xfer;
      wr_ptr_i = 12'd4;
      enable_i = 1'b1;
      for (int i = 0; i < 100 && n_xfer != start + 2; i++) @(negedge clk_i);
      check("t4_two_bytes", n_xfer, start + 2);
      enable_i = 1'b0;
      wait_idle("t4");
      repeat (10) @(negedge clk_i);
      #1;
      check("t4_rd_ptr", 32'(rd_ptr_o), 32'd2);
      check("t4_level", 32'(level_o), 32'd2);
      check("t4_busy", 32'(busy_o), 32'd0);

      // flush during SEND
      push_word(2, 32'hB4B3_B2B1, 1);
`ifdef CAPTURE_STREAMER_PREFETCH_EN
      push_read(3, 1);
`endif
      start    = n_xfer;
      wr_ptr_i = 12'd20;
      enable_i = 1'b1;
      for (int i = 0; i < 100 && n_xfer != start + 1; i++) @(negedge clk_i);
      check("t5_first_byte", n_xfer, start + 1);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      wait_idle("t5");
      repeat (10) @(negedge clk_i);
      #1;
      check("t5_rd_ptr", 32'(rd_ptr_o), 32'd20);
      check("t5_level", 32'(level_o), 32'd0);
      check("t5_busy", 32'(busy_o), 32'd0);

      // eight words back to back
      for (int unsigned k = 0; k < 8; k++) begin
         for (int unsigned b = 0; b < 4; b++) w[8*b +: 8] = 8'(8'h40 + 4*k + b);
         push_word(20 + k, w, 1);
      end
      xfer_log.delete();
      wr_ptr_i = 12'd28;
      wait_idle("t6");
      #1;
      check("t6_rd_ptr", 32'(rd_ptr_o), 32'd28);
      check("t6_level", 32'(level_o), 32'd0);
      check("t6_nbytes", xfer_log.size(), 32'd32);
      if (xfer_log.size() == 32) check("t6_span", xfer_log[31] - xfer_log[0], SPAN8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
